// File: rtl/input_sequencer.sv
// Debounced four-switch step sequencer: synchronizes raw switches, accepts one
// stable one-hot press per press/release cycle and offers it on a valid/ready port.
module input_sequencer #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_in,
    input  logic       step_ready,
    output logic       step_valid,
    output logic [1:0] step_code,
    output logic       multi_err,
    output logic       busy,
    output logic [7:0] accept_count
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        ISSUE,
        WAIT_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sw_sync_q, sw_sync_d;
    logic [3:0]    sample_q, sample_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_valid_q, step_valid_d;
    logic [1:0]    step_code_q, step_code_d;
    logic          multi_err_q, multi_err_d;
    logic [7:0]    accept_count_q, accept_count_d;
    logic          one_hot;

    // sample is never zero while debouncing, so the power-of-two test suffices
    assign one_hot = ((sample_q & (sample_q - 4'd1)) == 4'd0);

    always_comb begin
        sync1_d        = sw_in;
        sw_sync_d      = sync1_q;
        state_d        = state_q;
        sample_d       = sample_q;
        cnt_d          = cnt_q;
        step_valid_d   = step_valid_q;
        step_code_d    = step_code_q;
        multi_err_d    = 1'b0;
        accept_count_d = accept_count_q;

        case (state_q)
            IDLE: begin
                if (sw_sync_q != 4'd0) begin
                    sample_d = sw_sync_q;
                    cnt_d    = CNT_ONE;
                    state_d  = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sw_sync_q == 4'd0) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sw_sync_q != sample_q) begin
                    sample_d = sw_sync_q;
                    cnt_d    = CNT_ONE;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = '0;
                    if (one_hot) begin
                        step_code_d  = {sample_q[3] | sample_q[2], sample_q[3] | sample_q[1]};
                        step_valid_d = 1'b1;
                        state_d      = ISSUE;
                    end else begin
                        multi_err_d = 1'b1;
                        state_d     = WAIT_RELEASE;
                    end
                end
            end
            ISSUE: begin
                if (step_valid_q && step_ready) begin
                    step_valid_d   = 1'b0;
                    accept_count_d = accept_count_q + 8'd1;
                    cnt_d          = '0;
                    state_d        = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (sw_sync_q != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sync1_q        <= '0;
            sw_sync_q      <= '0;
            sample_q       <= '0;
            cnt_q          <= '0;
            step_valid_q   <= 1'b0;
            step_code_q    <= '0;
            multi_err_q    <= 1'b0;
            accept_count_q <= '0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sw_sync_q      <= sw_sync_d;
            sample_q       <= sample_d;
            cnt_q          <= cnt_d;
            step_valid_q   <= step_valid_d;
            step_code_q    <= step_code_d;
            multi_err_q    <= multi_err_d;
            accept_count_q <= accept_count_d;
        end
    end

    assign step_valid   = step_valid_q;
    assign step_code    = step_code_q;
    assign multi_err    = multi_err_q;
    assign busy         = (state_q != IDLE);
    assign accept_count = accept_count_q;

endmodule

// File: tb/tb_input_sequencer.sv
// Directed bench for input_sequencer: inputs change and outputs are sampled on
// the falling clock edge; expected values are hand-derived edge by edge.
module tb_input_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw_in;
    logic       step_ready;
    logic       step_valid;
    logic [1:0] step_code;
    logic       multi_err;
    logic       busy;
    logic [7:0] accept_count;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_count;
    int         n_press;

    always #5 clk = ~clk;

    input_sequencer #(.DEB_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_in        (sw_in),
        .step_ready   (step_ready),
        .step_valid   (step_valid),
        .step_code    (step_code),
        .multi_err    (multi_err),
        .busy         (busy),
        .accept_count (accept_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        int i = 0;
        while (step_valid !== 1'b1 && i < budget) begin
            cyc(1);
            i++;
        end
        chk("wait_valid", step_valid, 1);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy !== 1'b0 && i < budget) begin
            cyc(1);
            i++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic press_sw0();
        sw_in      = 4'b0001;
        step_ready = 1'b1;
        cyc(1);
        wait_valid(12);
        chk("press_code", step_code, 0);
        cyc(1);
        exp_count = exp_count + 8'd1;
        chk("press_count", accept_count, exp_count);
        sw_in = 4'b0000;
        wait_idle(12);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        sw_in      = 4'b0000;
        step_ready = 1'b0;
        exp_count  = 8'd0;
        cyc(3);
        chk("rst_valid", step_valid, 0);
        chk("rst_code", step_code, 0);
        chk("rst_multi", multi_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", accept_count, 0);
        reset = 1'b0;
        cyc(1);

        // Clean SW2 press with ready already high: valid on the 6th edge
        sw_in      = 4'b0100;
        step_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk("s1_valid_low", step_valid, 0);
            chk("s1_busy", busy, (k >= 3) ? 1 : 0);
        end
        cyc(1);
        chk("s1_valid_rise", step_valid, 1);
        chk("s1_code", step_code, 2'b10);
        chk("s1_no_early_xfer", accept_count, 0);
        cyc(1);
        exp_count = 8'd1;
        chk("s1_valid_drop", step_valid, 0);
        chk("s1_count", accept_count, exp_count);
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk("s1_no_repeat", step_valid, 0);
        end
        sw_in = 4'b0000;
        cyc(5);
        chk("s1_busy_release", busy, 1);
        cyc(1);
        chk("s1_idle", busy, 0);

        // SW1 bouncing every 2 cycles, then held
        for (int i = 0; i < 10; i++) begin
            sw_in = (((i / 2) % 2) == 0) ? 4'b0010 : 4'b0000;
            cyc(1);
            chk("s2_bounce_valid", step_valid, 0);
        end
        sw_in = 4'b0010;
        wait_valid(12);
        chk("s2_code", step_code, 2'b01);
        cyc(1);
        exp_count = 8'd2;
        chk("s2_count", accept_count, exp_count);
        sw_in = 4'b0000;
        wait_idle(12);

        // Two switches held: one-cycle multi_err, no step
        sw_in      = 4'b1010;
        step_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            chk("s3_multi", multi_err, (k == 6) ? 1 : 0);
            chk("s3_valid", step_valid, 0);
        end
        sw_in = 4'b0000;
        cyc(5);
        chk("s3_busy_release", busy, 1);
        cyc(1);
        chk("s3_idle", busy, 0);
        chk("s3_count", accept_count, exp_count);

        // SW3 with ready low; switch released while the step is pending
        sw_in      = 4'b1000;
        step_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (k >= 6) begin
                chk("s4_valid_hold", step_valid, 1);
                chk("s4_code", step_code, 2'b11);
            end else begin
                chk("s4_valid_low", step_valid, 0);
            end
            if (k == 8) sw_in = 4'b0000;
        end
        step_ready = 1'b1;
        cyc(1);
        exp_count = 8'd3;
        chk("s4_valid_drop", step_valid, 0);
        chk("s4_count", accept_count, exp_count);
        wait_idle(12);

        // Clean presses until the counter wraps
        n_press = 256 - int'(exp_count);
        repeat (n_press) press_sw0();
        chk("s5_wrap", accept_count, 0);

        // Switch held through WAIT_RELEASE: no second step
        sw_in      = 4'b0001;
        step_ready = 1'b1;
        cyc(1);
        wait_valid(12);
        cyc(1);
        exp_count = exp_count + 8'd1;
        chk("s5_hold_count", accept_count, exp_count);
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            chk("s5_hold_valid", step_valid, 0);
            chk("s5_hold_busy", busy, 1);
        end
        sw_in = 4'b0000;
        wait_idle(12);
        chk("s5_hold_count_end", accept_count, 1);

        // Reset while a step is pending, switch kept held
        sw_in      = 4'b0100;
        step_ready = 1'b0;
        cyc(1);
        wait_valid(12);
        chk("s6_code_pre", step_code, 2'b10);
        reset = 1'b1;
        cyc(1);
        exp_count = 8'd0;
        chk("s6_valid", step_valid, 0);
        chk("s6_code", step_code, 0);
        chk("s6_multi", multi_err, 0);
        chk("s6_busy", busy, 0);
        chk("s6_count", accept_count, exp_count);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk("s6_relatency_low", step_valid, 0);
        end
        cyc(1);
        chk("s6_reissue", step_valid, 1);
        chk("s6_reissue_code", step_code, 2'b10);
        step_ready = 1'b1;
        cyc(1);
        exp_count = 8'd1;
        chk("s6_xfer", step_valid, 0);
        chk("s6_count_after", accept_count, exp_count);
        sw_in = 4'b0000;
        wait_idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
